// File: rtl/dmem_responder.sv
// Data-memory responder: one 64-bit load/store per transaction, fixed LATENCY
// between request acceptance and a one-cycle response pulse.
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        stall,
    output logic [63:0] dbg_word0,
    output logic [1:0]  dbg_state
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam int          CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic          r_resp_error;
    logic [63:0]   r_resp_rdata;
    logic          r_write;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_mem [DEPTH_WORDS];

    logic          w_err;
    logic [AW-1:0] w_idx;

    // Decode works on the latched address, so inputs only matter at the accept edge.
    assign w_err = (r_addr[2:0] != 3'b000) || (r_addr >= LIMIT);
    assign w_idx = r_addr[3 +: AW];

    // Handshake: a request transfers on a rising edge where req_valid and req_ready
    // are both high; the response is a single resp_valid pulse with no backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= CW'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= w_err;
                        if (w_err || r_write) begin
                            r_resp_rdata <= '0;
                        end else begin
                            r_resp_rdata <= r_mem[w_idx];
                        end
                        if (!w_err && r_write) begin
                            r_mem[w_idx] <= r_wdata;
                        end
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_error <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_error = r_resp_error;
    assign stall      = req_valid & ~r_req_ready;
    assign dbg_word0  = r_mem[0];
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance for most scenarios, LATENCY=1
// instance for the back-to-back spacing check.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    int   cyc   = 0;
    always @(posedge clk) cyc++;

    // LATENCY=2 instance
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_error, stall;
    logic [63:0] resp_rdata, dbg_word0;
    logic [1:0]  dbg_state;

    // LATENCY=1 instance
    logic        req_valid_1 = 1'b0, req_write_1 = 1'b0;
    logic [63:0] req_addr_1 = '0, req_wdata_1 = '0;
    logic        req_ready_1, resp_valid_1, resp_error_1, stall_1;
    logic [63:0] resp_rdata_1, dbg_word0_1;
    logic [1:0]  dbg_state_1;

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .stall(stall), .dbg_word0(dbg_word0), .dbg_state(dbg_state)
    );

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
        .req_addr(req_addr_1), .req_wdata(req_wdata_1),
        .resp_valid(resp_valid_1), .resp_rdata(resp_rdata_1), .resp_error(resp_error_1),
        .stall(stall_1), .dbg_word0(dbg_word0_1), .dbg_state(dbg_state_1)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard: {error, rdata} expected per response, plus a memory model per instance.
    logic [64:0] exp_q[$];
    logic [64:0] exp_q1[$];
    logic [63:0] model0 [32];
    logic [63:0] model1 [32];

    function automatic void clear_models();
        for (int i = 0; i < 32; i++) begin
            model0[i] = '0;
            model1[i] = '0;
        end
    endfunction

    function automatic void expect_push(input int which, input logic w,
                                        input logic [63:0] a, input logic [63:0] d);
        logic [64:0] e;
        logic        err;
        err = (a[2:0] != 3'b000) || (a >= 64'd256);
        if (err) e = {1'b1, 64'd0};
        else if (w) e = {1'b0, 64'd0};
        else e = {1'b0, (which == 0) ? model0[a[7:3]] : model1[a[7:3]]};
        if (!err && w) begin
            if (which == 0) model0[a[7:3]] = d;
            else model1[a[7:3]] = d;
        end
        if (which == 0) exp_q.push_back(e);
        else exp_q1.push_back(e);
    endfunction

    function automatic logic rdy(input int which);
        return (which == 0) ? req_ready : req_ready_1;
    endfunction

    function automatic logic stall_of(input int which);
        return (which == 0) ? stall : stall_1;
    endfunction

    always @(negedge clk) begin
        logic [64:0] e;
        if (resp_valid === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL resp0_unexpected: got err=%b data=%h, no response expected",
                         resp_error, resp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({resp_error, resp_rdata} !== e)
                    $display("FAIL resp0_data: got err=%b data=%h, want err=%b data=%h",
                             resp_error, resp_rdata, e[64], e[63:0]);
                else n_pass++;
            end
        end
        if (resp_valid_1 === 1'b1) begin
            n_total++;
            if (exp_q1.size() == 0) begin
                $display("FAIL resp1_unexpected: got err=%b data=%h, no response expected",
                         resp_error_1, resp_rdata_1);
            end else begin
                e = exp_q1.pop_front();
                if ({resp_error_1, resp_rdata_1} !== e)
                    $display("FAIL resp1_data: got err=%b data=%h, want err=%b data=%h",
                             resp_error_1, resp_rdata_1, e[64], e[63:0]);
                else n_pass++;
            end
        end
    end

    task automatic drive(input int which, input logic v, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
        if (which == 0) begin
            req_valid = v; req_write = w; req_addr = a; req_wdata = d;
        end else begin
            req_valid_1 = v; req_write_1 = w; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    // Presents one request, returns the cycle number of its accept edge with valid dropped.
    task automatic send(input int which, input logic w, input logic [63:0] a,
                        input logic [63:0] d, output int acc);
        int t = 0;
        drive(which, 1'b1, w, a, d);
        expect_push(which, w, a, d);
        while (!rdy(which) && t < 20) begin
            @(posedge clk); #1; t++;
        end
        n_total++;
        if (t >= 20) $display("FAIL send_accept: waited %0d cycles, limit 20", t);
        else n_pass++;
        @(posedge clk); #1;
        acc = cyc;
        drive(which, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || exp_q1.size() != 0) && t < 30) begin
            @(posedge clk); #1; t++;
        end
        n_total++;
        if (exp_q.size() != 0 || exp_q1.size() != 0)
            $display("FAIL drain: pending %0d/%0d responses, want 0/0", exp_q.size(), exp_q1.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
        n_total++;
        if (resp_rdata !== 64'd0 || resp_error !== 1'b0)
            $display("FAIL rst_resp: got data=%h err=%b want 0/0", resp_rdata, resp_error);
        else n_pass++;
        n_total++;
        if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else n_pass++;
        n_total++;
        if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
        reset = 1'b0;
        clear_models();
        @(posedge clk); #1;
        req_valid = 1'b1;
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL idle_stall: got %b want 0", stall); else n_pass++;
        req_valid = 1'b0;
    endtask

    task automatic test_load_zero();
        int acc;
        n_total++;
        if (dbg_word0 !== 64'd0) $display("FAIL word0_reset: got %h want 0", dbg_word0); else n_pass++;
        send(0, 1'b0, 64'h0, 64'h0, acc);
        drain();
        send(0, 1'b1, 64'h0, 64'h5, acc);
        @(posedge clk); #1;
        n_total++;
        if (dbg_word0 !== 64'd0) $display("FAIL word0_precommit: got %h want 0", dbg_word0); else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (dbg_word0 !== 64'd5) $display("FAIL word0_commit: got %h want 5", dbg_word0); else n_pass++;
        drain();
    endtask

    task automatic test_store_latency();
        int acc;
        send(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, acc);
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL lat_ready_k0: got %b want 0", req_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL lat_k1: got ready=%b valid=%b want 0/0", req_ready, resp_valid);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b1)
            $display("FAIL lat_k2: got ready=%b valid=%b want 0/1", req_ready, resp_valid);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL lat_k3: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
        else n_pass++;
        drain();
        send(0, 1'b0, 64'h10, 64'h0, acc);
        drain();
    endtask

    task automatic test_misaligned();
        int acc;
        send(0, 1'b1, 64'h14, 64'h1111_2222_3333_4444, acc);
        drain();
        send(0, 1'b0, 64'h10, 64'h0, acc);
        send(0, 1'b0, 64'h11, 64'h0, acc);
        drain();
    endtask

    task automatic test_out_of_range();
        int acc;
        send(0, 1'b0, 64'h100, 64'h0, acc);
        send(0, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, acc);
        send(0, 1'b1, 64'hF8, 64'hA5A5_0000_1234_5678, acc);
        send(0, 1'b0, 64'hF8, 64'h0, acc);
        send(0, 1'b0, 64'h0, 64'h0, acc);
        send(0, 1'b0, 64'h8000_0000_0000_0000, 64'h0, acc);
        drain();
    endtask

    task automatic test_back_to_back(input int which, input int lat);
        int          acc[5];
        int          t;
        logic        w;
        logic [63:0] a, d, prev_a;
        prev_a = '0;
        for (int i = 0; i < 5; i++) begin
            w = ($urandom_range(0, 1) == 1);
            a = 64'($urandom_range(0, 31)) * 64'd8;
            d = {$urandom, $urandom};
            if (i == 3) w = 1'b1;
            if (i == 4) begin w = 1'b0; a = prev_a; end
            prev_a = a;
            drive(which, 1'b1, w, a, d);
            expect_push(which, w, a, d);
            t = 0;
            while (!rdy(which) && t < 20) begin
                n_total++;
                if (stall_of(which) !== 1'b1)
                    $display("FAIL b2b%0d_stall_busy: got %b want 1", which, stall_of(which));
                else n_pass++;
                @(posedge clk); #1; t++;
            end
            n_total++;
            if (t >= 20) $display("FAIL b2b%0d_accept: waited %0d cycles, limit 20", which, t);
            else n_pass++;
            n_total++;
            if (stall_of(which) !== 1'b0)
                $display("FAIL b2b%0d_stall_idle: got %b want 0", which, stall_of(which));
            else n_pass++;
            @(posedge clk); #1;
            acc[i] = cyc;
        end
        drive(which, 1'b0, 1'b0, 64'd0, 64'd0);
        for (int i = 1; i < 5; i++) begin
            n_total++;
            if (acc[i] - acc[i-1] != lat + 2)
                $display("FAIL b2b%0d_spacing: got %0d cycles want %0d", which, acc[i] - acc[i-1], lat + 2);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_reset_on_commit();
        int acc;
        send(0, 1'b1, 64'h8, 64'h7, acc);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        clear_models();
        n_total++;
        if (dbg_state !== 2'd0) $display("FAIL roc_state: got %0d want 0", dbg_state); else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL roc_valid: got %b want 0", resp_valid); else n_pass++;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL roc_ready: got %b want 1", req_ready); else n_pass++;
        n_total++;
        if (dbg_word0 !== 64'd0) $display("FAIL roc_word0: got %h want 0", dbg_word0); else n_pass++;
        send(0, 1'b0, 64'h8, 64'h0, acc);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        clear_models();
        test_reset();
        test_load_zero();
        test_store_latency();
        test_misaligned();
        test_out_of_range();
        test_back_to_back(0, 2);
        test_back_to_back(1, 1);
        test_reset_on_commit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port; serves one load or store doubleword (64-bit) per transaction.
- Core side is the initiator: presents address, write data and read/write intent with a valid/ready request handshake, then waits for a one-cycle response pulse.
- Latency is configurable so pipeline stall logic can be exercised against a non-single-cycle memory. Sits between the EX/MEM register and the MEM/WB register.

Parameters:
- DEPTH_WORDS, 32, number of 64-bit words stored; power of two, minimum 2.
- LATENCY, 2, cycles from request acceptance to response; minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store (sd), 0 = load (ld).
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  64  load data; 0 for stores and errors.
- resp_error  output  1  misaligned or out-of-range access; valid with resp_valid.
- stall  output  1  equals req_valid AND NOT req_ready; core holds its pipeline while high.
- dbg_word0  output  64  current contents of word 0, combinational from the array.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset (sampled on a rising edge):
  - state goes to IDLE; counter cleared.
  - All DEPTH_WORDS words cleared to 0.
  - resp_valid=0, resp_rdata=0, resp_error=0; latched request cleared.
- Reset has priority over every other action.
  - Reset asserted mid-transaction aborts it.
  - No write commits on an edge where reset is high, even if that edge would have committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid=1 at an edge: latch req_write, req_addr, req_wdata; set cnt=LATENCY-1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - req_ready=0.
  - If cnt≠0: decrement cnt and stay in WAIT.
  - If cnt=0, commit the access on this edge and go to RESP.
  - Commit for a load: resp_rdata <= mem[idx].
  - Commit for a store: mem[idx] <= latched wdata, resp_rdata <= 0.
- RESP:
  - req_ready=0; resp_valid=1 for exactly this one cycle.
  - Next edge: go to IDLE and clear resp_valid, resp_rdata and resp_error.
  - A request presented during RESP is not accepted; it waits for IDLE.
- Timing: a request accepted at edge k gives resp_valid=1 in the cycle after edge k+LATENCY. Throughput is one transaction per LATENCY+2 cycles.
- Address decode:
  - idx = req_addr[3 +: log2(DEPTH_WORDS)].
  - Error if req_addr[2:0]≠0 (misaligned) or req_addr ≥ DEPTH_WORDS*8 (out of range).
  - On error: no array write, resp_rdata=0, resp_error=1 in RESP, same latency as a normal access.
- Request inputs are sampled only at the accepting edge. Later changes during WAIT/RESP have no effect.
- Read-after-write: a load to a just-stored word returns the new data; the store commits before the next request can be accepted.
- req_valid dropping while in WAIT has no effect; the transaction completes.
- No response backpressure; the core must consume resp_valid in its pulse cycle.

Test Plan:
- Reset, then store addr=0x10 wdata=0xDEADBEEF_CAFEF00D with LATENCY=2 → req_ready=0 for 3 cycles; resp_valid pulses once in the cycle after edge k+2 with resp_rdata=0, resp_error=0. A following load of 0x10 returns 0xDEADBEEF_CAFEF00D.
- Load addr=0x0 right after reset → resp_rdata=0, resp_error=0; dbg_word0=0. Then store 0x0 with 0x5 → dbg_word0=5 starting the cycle after the commit edge.
- Misaligned store addr=0x14 → resp_error=1, resp_rdata=0; a subsequent load of 0x10 returns the old value unchanged.
- Out-of-range load addr=0x100 (DEPTH_WORDS=32) → resp_error=1.
- req_valid held high with back-to-back requests → accepted only in IDLE; stall=1 during WAIT and RESP; consecutive accept edges are exactly LATENCY+2 cycles apart. Repeat with LATENCY=1 → 3-cycle spacing.
- Store 0x7 to addr 0x8, then assert reset exactly on its commit edge → word 1 reads 0 after reset; state IDLE, resp_valid=0, req_ready=1 on the following cycle.
